// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: NS/EW green-yellow phases separated by all-red
// clearance, a latched pedestrian walk phase, and a flashing-yellow maintenance mode.
module traffic_intersection_ctrl #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned PED_CYCLES    = 5,
  parameter int unsigned FLASH_HALF    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_e;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_GRN  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_YEL  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_AR   = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PED  = CNT_W'(PED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_FLSH = CNT_W'(FLASH_HALF - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               fon_q, fon_d;
  logic               pend_q, pend_d;
  logic [2:0]         ns_q, ns_d;
  logic [2:0]         ew_q, ew_d;
  logic               walk_q, walk_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    fon_d   = fon_q;
    pend_d  = pend_q;

    if (ped_req && state_q != PED_WALK) pend_d = 1'b1;

    if (flash_en) begin
      if (state_q != FLASH) begin
        state_d = FLASH;
        fcnt_d  = LD_FLSH;
        fon_d   = 1'b1;
      end else if (fcnt_q == '0) begin
        fcnt_d = LD_FLSH;
        fon_d  = ~fon_q;
      end else begin
        fcnt_d = fcnt_q - ONE;
      end
    end else if (state_q == FLASH) begin
      state_d = ALLRED_A;
      cnt_d   = LD_AR;
    end else if (cnt_q == '0) begin
      unique case (state_q)
        ALLRED_A: begin
          if (pend_q) begin
            // Entering the walk serves the request, including one arriving this cycle.
            state_d = PED_WALK;
            cnt_d   = LD_PED;
            pend_d  = 1'b0;
          end else begin
            state_d = NS_GREEN;
            cnt_d   = LD_GRN;
          end
        end
        PED_WALK:  begin state_d = NS_GREEN;  cnt_d = LD_GRN; end
        NS_GREEN:  begin state_d = NS_YELLOW; cnt_d = LD_YEL; end
        NS_YELLOW: begin state_d = ALLRED_B;  cnt_d = LD_AR;  end
        ALLRED_B:  begin state_d = EW_GREEN;  cnt_d = LD_GRN; end
        EW_GREEN:  begin state_d = EW_YELLOW; cnt_d = LD_YEL; end
        EW_YELLOW: begin state_d = ALLRED_A;  cnt_d = LD_AR;  end
        default:   begin state_d = ALLRED_A;  cnt_d = LD_AR;  end
      endcase
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Lamps are decoded from the next state so the registered outputs track the state with no lag.
  always_comb begin
    ns_d   = RED;
    ew_d   = RED;
    walk_d = 1'b0;
    unique case (state_d)
      NS_GREEN:  ns_d = GRN;
      NS_YELLOW: ns_d = YEL;
      EW_GREEN:  ew_d = GRN;
      EW_YELLOW: ew_d = YEL;
      PED_WALK:  walk_d = 1'b1;
      FLASH: begin
        ns_d = fon_d ? YEL : DARK;
        ew_d = fon_d ? YEL : DARK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALLRED_A;
      cnt_q   <= LD_AR;
      fcnt_q  <= '0;
      fon_q   <= 1'b0;
      pend_q  <= 1'b0;
      ns_q    <= RED;
      ew_q    <= RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      fon_q   <= fon_d;
      pend_q  <= pend_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign ped_walk    = walk_q;
  assign ped_pending = pend_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed checks of the intersection controller: default timing, pedestrian latch,
// flash mode, mid-sequence reset, and a minimum-duration parameter set.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset, ped_req, flash_en;
  logic [2:0] ns, ew, ph;
  logic       walk, pend;

  logic       reset1, ped1, flash1;
  logic [2:0] ns1, ew1, ph1;
  logic       walk1, pend1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_en(flash_en),
    .ns_light(ns), .ew_light(ew), .ped_walk(walk), .ped_pending(pend), .phase(ph)
  );

  traffic_intersection_ctrl #(
    .CNT_W(2), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1),
    .PED_CYCLES(1), .FLASH_HALF(1)
  ) dut_min (
    .clk(clk), .reset(reset1), .ped_req(ped1), .flash_en(flash1),
    .ns_light(ns1), .ew_light(ew1), .ped_walk(walk1), .ped_pending(pend1), .phase(ph1)
  );

  // Default-parameter phase at cycle c when no pedestrian or flash activity occurs.
  function automatic logic [2:0] seq_phase(input int c);
    int m;
    m = c % 26;
    if (m < 2)  return 3'd0;
    if (m < 10) return 3'd1;
    if (m < 13) return 3'd2;
    if (m < 15) return 3'd3;
    if (m < 23) return 3'd4;
    return 3'd5;
  endfunction

  // {ns, ew} lamp pattern expected for a phase; on selects the flash half.
  function automatic logic [5:0] lamps(input logic [2:0] p, input logic on);
    case (p)
      3'd1:    return 6'b001_100;
      3'd2:    return 6'b010_100;
      3'd4:    return 6'b100_001;
      3'd5:    return 6'b100_010;
      3'd7:    return on ? 6'b010_010 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [10:0] pack_exp(input logic [2:0] p, input logic on, input logic pn);
    return {p, lamps(p, on), (p == 3'd6), pn};
  endfunction

  task automatic do_reset();
    reset = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    reset = 1'b1; ped_req = 1'b1; flash_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = 11'b000_100_100_0_0;
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, {ph, ns, ew, walk, pend}, exp_v);
      end
    end
    reset = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
  endtask

  task automatic test_sequence();
    logic [10:0] exp_v;
    do_reset();
    for (int c = 0; c <= 52; c++) begin
      exp_v = pack_exp(seq_phase(c), 1'b0, 1'b0);
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL sequence c=%0d: got %b expected %b", c, {ph, ns, ew, walk, pend}, exp_v);
      end
      n_checks++;
      if (ph != 3'd7 && ns != 3'b100 && ew != 3'b100) begin
        n_fail++;
        $display("FAIL safety c=%0d: ns=%b ew=%b expected one road red", c, ns, ew);
      end
      @(negedge clk);
    end
  endtask

  // hold=1 also keeps ped_req high across the edge entering the walk and during it.
  task automatic test_ped(input bit hold);
    logic [10:0] exp_v;
    logic [2:0]  p;
    int          last;
    last = hold ? 59 : 33;
    do_reset();
    for (int c = 0; c <= last; c++) begin
      if (c < 28)      p = seq_phase(c);
      else if (c < 33) p = 3'd6;
      else             p = seq_phase(c - 31);
      exp_v = pack_exp(p, 1'b0, (c >= 6 && c < 28));
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL ped(hold=%0d) c=%0d: got %b expected %b", hold, c, {ph, ns, ew, walk, pend}, exp_v);
      end
      ped_req = (c == 5) || (hold && (c == 27 || c == 28));
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_flash();
    logic [10:0] exp_v;
    logic [2:0]  p;
    logic        on;
    do_reset();
    for (int c = 0; c <= 29; c++) begin
      on = 1'b1;
      if (c < 5)        p = seq_phase(c);
      else if (c < 15)  begin p = 3'd7; on = (((c - 5) / 4) % 2) == 0; end
      else if (c < 17)  p = 3'd0;
      else if (c < 19)  p = 3'd1;
      else if (c < 22)  p = 3'd7;
      else if (c < 24)  p = 3'd0;
      else if (c < 29)  p = 3'd6;
      else              p = 3'd1;
      exp_v = pack_exp(p, on, (c >= 21 && c < 24));
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL flash c=%0d: got %b expected %b", c, {ph, ns, ew, walk, pend}, exp_v);
      end
      flash_en = (c >= 4 && c < 14) || (c >= 18 && c < 21);
      ped_req  = (c == 20);
      @(negedge clk);
    end
    flash_en = 1'b0; ped_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp_v;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      exp_v = pack_exp(seq_phase(c), 1'b0, (c >= 4));
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset c=%0d: got %b expected %b", c, {ph, ns, ew, walk, pend}, exp_v);
      end
      ped_req = (c == 3);
      if (c < 17) @(negedge clk);
    end
    ped_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      exp_v = pack_exp(seq_phase(c), 1'b0, 1'b0);
      n_checks++;
      if ({ph, ns, ew, walk, pend} !== exp_v) begin
        n_fail++;
        $display("FAIL post_reset c=%0d: got %b expected %b", c, {ph, ns, ew, walk, pend}, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_min_durations();
    logic [10:0] exp_v;
    logic [2:0]  p;
    logic        on;
    reset1 = 1'b1; ped1 = 1'b0; flash1 = 1'b0;
    repeat (2) @(negedge clk);
    reset1 = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      on = 1'b1;
      if (c < 9)        p = 3'(c % 6);
      else if (c < 14)  begin p = 3'd7; on = ((c - 9) % 2) == 0; end
      else if (c < 21)  p = 3'((c - 14) % 6);
      else if (c == 21) p = 3'd6;
      else              p = 3'd1;
      exp_v = pack_exp(p, on, (c >= 16 && c < 21));
      n_checks++;
      if ({ph1, ns1, ew1, walk1, pend1} !== exp_v) begin
        n_fail++;
        $display("FAIL min_dur c=%0d: got %b expected %b", c, {ph1, ns1, ew1, walk1, pend1}, exp_v);
      end
      n_checks++;
      if (ph1 != 3'd7 && ns1 != 3'b100 && ew1 != 3'b100) begin
        n_fail++;
        $display("FAIL min_safety c=%0d: ns=%b ew=%b expected one road red", c, ns1, ew1);
      end
      flash1 = (c >= 8 && c < 13);
      ped1   = (c == 15);
      @(negedge clk);
    end
    flash1 = 1'b0; ped1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
    reset1 = 1'b1; ped1 = 1'b0; flash1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_ped(1'b0);
    test_ped(1'b1);
    test_flash();
    test_reset_mid();
    test_min_durations();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
